// File: rtl/serial_reduce_pkg.sv
// Shared definitions for the serial reduction stage: default word width,
// counter-width helper and the derived occupancy state encoding.
package serial_reduce_pkg;

    localparam int WIDTH_DEF = 8;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_COLLECT,
        ST_HOLD,
        ST_HOLD_COLLECT
    } stage_state_e;

endpackage

// File: rtl/bit_collector.sv
// Serial-to-parallel collector: LSB-first shift register with wrapping bit
// counter; flags the transfer that supplies the final bit of a word.
module bit_collector
    import serial_reduce_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             take,
    input  logic             in_bit,
    output logic [CNT_W-1:0] cnt,
    output logic             complete,
    output logic [WIDTH-1:0] word
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Only the first WIDTH-1 bits are stored; the final bit goes straight
    // from in_bit into the assembled word.
    logic [WIDTH-2:0] shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            shift <= '0;
        end else if (flush) begin
            cnt   <= '0;
            shift <= '0;
        end else if (take) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                shift[cnt] <= in_bit;
                cnt        <= cnt + CNT_W'(1);
            end
        end
    end

    assign complete = take && !flush && (cnt == LAST);
    assign word     = {in_bit, shift};

endmodule

// File: rtl/serial_reduce_stage.sv
// Serial operand stage: assembles WIDTH-bit words and presents each with its
// AND/OR/XOR reductions through a one-word valid/ready output buffer.
module serial_reduce_stage
    import serial_reduce_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;
    logic             complete;
    logic [WIDTH-1:0] word;
    logic             take;
    stage_state_e     state;

    bit_collector #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_collector (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .take    (take),
        .in_bit  (in_bit),
        .cnt     (cnt),
        .complete(complete),
        .word    (word)
    );

    // Occupancy state is implied by the counter and the buffer flag.
    always_comb begin
        state = ST_EMPTY;
        if (out_valid) begin
            state = (cnt == '0) ? ST_HOLD : ST_HOLD_COLLECT;
        end else if (cnt != '0) begin
            state = ST_COLLECT;
        end
    end

    // Only the word-completing bit has to wait for a full, unread buffer.
    always_comb begin
        in_ready = 1'b1;
        if (state == ST_HOLD_COLLECT && cnt == LAST && !out_ready) begin
            in_ready = 1'b0;
        end
    end

    assign take = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            red_and   <= 1'b0;
            red_or    <= 1'b0;
            red_xor   <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_word  <= word;
            red_and   <= &word;
            red_or    <= |word;
            red_xor   <= ^word;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_reduce_stage.sv
// Scoreboard bench for serial_reduce_stage: directed scenarios plus random
// words with random back-pressure, checked against a bit-list reference model.
module tb_serial_reduce_stage;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_bit;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;
    logic         red_and;
    logic         red_or;
    logic         red_xor;

    int total = 0;
    int bad   = 0;
    int words_out = 0;
    logic [W+2:0] exp_q[$];
    logic         part_q[$];
    logic         rand_ready = 1'b0;

    always #5 clk = ~clk;

    serial_reduce_stage #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .red_and  (red_and),
        .red_or   (red_or),
        .red_xor  (red_xor)
    );

    function automatic logic [W+2:0] ref_entry(input logic [W-1:0] w);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(w[i]);
        return {w, 1'(ones == W), 1'(ones > 0), 1'(ones % 2 == 1)};
    endfunction

    function automatic void model_accept(input logic b);
        logic [W-1:0] w;
        part_q.push_back(b);
        if (part_q.size() == W) begin
            for (int i = 0; i < W; i++) w[i] = part_q[i];
            exp_q.push_back(ref_entry(w));
            part_q.delete();
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every negedge with out_valid either holds (value must match the
    // pending expectation) or completes a transfer at the next edge.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got=%0h want=none at %0t", out_word, $time);
            end else begin
                if ({out_word, red_and, red_or, red_xor} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL word_reds got=%0h want=%0h at %0t",
                             {out_word, red_and, red_or, red_xor}, exp_q[0], $time);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    words_out++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offers one bit until accepted; called at posedge+1, returns at posedge+1.
    task automatic send_bit(input logic b, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_bit   = b;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(b);
                break;
            end
            waits++;
            if (waits > 100) begin
                check("in_ready_timeout", 32'(waits), 32'(0));
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bit   = 1'bx;
    endtask

    task automatic send_word(input logic [W-1:0] w, output int stalls);
        int wt;
        stalls = 0;
        for (int i = 0; i < W; i++) begin
            send_bit(w[i], wt);
            stalls += wt;
        end
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'bx;
        part_q.delete();
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_rst_word"}, 32'(out_word), 32'(0));
        check({tag, "_rst_reds"}, 32'({red_and, red_or, red_xor}), 32'(0));
        exp_q.delete();
        part_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check({tag, "_rst_in_ready"}, 32'(in_ready), 32'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int st;
        int wt;
        int start_out;
        logic [W-1:0] w2;
        logic [W-1:0] rw;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'(0));
        check("reset_word", 32'(out_word), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: LSB-first assembly and one-cycle latency
        out_ready = 1'b1;
        send_word(8'b0000_1101 | 8'b1000_0000, st);
        check("t1_word", 32'(out_word), 32'h8D);
        check("t1_valid", 32'(out_valid), 32'(1));
        check("t1_reds", 32'({red_and, red_or, red_xor}), 32'b010);
        @(posedge clk); #1;

        // 2: hold with back-pressure, stall on last bit, drain and load same edge
        out_ready = 1'b0;
        send_word(8'hFF, st);
        w2 = W'($urandom);
        for (int i = 0; i < W - 1; i++) begin
            send_bit(w2[i], wt);
            check("t2_no_stall", 32'(wt), 32'(0));
        end
        check("t2_hold_word", 32'(out_word), 32'hFF);
        check("t2_hold_and", 32'(red_and), 32'(1));
        in_valid = 1'b1;
        in_bit   = w2[W-1];
        @(negedge clk);
        check("t2_stall_last", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_ready_again", 32'(in_ready), 32'(1));
        if (in_ready) model_accept(w2[W-1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bit   = 1'bx;
        check("t2_load_valid", 32'(out_valid), 32'(1));
        check("t2_load_word", 32'(out_word), 32'(w2));
        @(posedge clk); #1;

        // 3: continuous stream, no bubbles, no lost bits
        start_out = words_out;
        wt = 0;
        for (int k = 0; k < 4; k++) begin
            send_word(W'($urandom), st);
            wt += st;
        end
        repeat (2) @(posedge clk);
        #1;
        check("t3_stalls", 32'(wt), 32'(0));
        check("t3_words", 32'(words_out - start_out), 32'(4));

        // 4: flush drops partial bits
        for (int i = 0; i < 5; i++) send_bit(1'b1, wt);
        do_flush();
        send_word(8'h01, st);
        check("t4_word", 32'(out_word), 32'h01);
        check("t4_reds", 32'({red_and, red_or, red_xor}), 32'b011);
        @(posedge clk); #1;

        // 5: reset mid-word, then mid-hold
        for (int i = 0; i < 3; i++) send_bit(1'b1, wt);
        async_reset("t5a");
        out_ready = 1'b0;
        send_word(8'hA5, st);
        send_bit(1'b1, wt);
        send_bit(1'b0, wt);
        async_reset("t5b");
        check("t5_no_output", 32'(out_valid), 32'(0));

        // 6: reduction corners
        out_ready = 1'b1;
        send_word(8'h00, st);
        check("t6_zero_reds", 32'({red_and, red_or, red_xor}), 32'b000);
        send_word(8'h7F, st);
        check("t6_7f_reds", 32'({red_and, red_or, red_xor}), 32'b011);
        @(posedge clk); #1;

        // Random words under random back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rw = W'($urandom);
            send_word(rw, st);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 12)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && (exp_q.size() > 0 || out_valid); c++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        check("drain_valid", 32'(out_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
